// File: rtl/gate_check_seq_if.sv
// Bus between the truth-table sequencer and the gate/control-model pair it exercises.
// master: sequencer side; slave: environment driving start and the gate outputs.
interface gate_check_seq_if #(
  parameter int N_IN = 2
);
  logic              start;
  logic              dut_s;
  logic              ref_s;
  logic [N_IN-1:0]   stim;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic [N_IN-1:0]   first_err_vec;
  logic              first_err_valid;

  modport master (
    input  start, dut_s, ref_s,
    output stim, busy, done, pass, err_count, first_err_vec, first_err_valid
  );

  modport slave (
    output start, dut_s, ref_s,
    input  stim, busy, done, pass, err_count, first_err_vec, first_err_valid
  );
endinterface

// File: rtl/gate_check_seq.sv
// Clocked truth-table checker: walks stim over all 2**N_IN vectors, holds each for
// SETTLE cycles, then compares gate output against the control model for one cycle.
module gate_check_seq #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  gate_check_seq_if.master bus
);
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  typedef enum logic [1:0] {IDLE, DRIVE, CMP, DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] fvec_q, fvec_d;
  logic            fval_q, fval_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fvec_q  <= '0;
      fval_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fval_q  <= fval_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fval_d  = fval_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = DRIVE;
          stim_d  = '0;
          cnt_d   = SETTLE_C;
          err_d   = '0;
          fvec_d  = '0;
          fval_d  = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = CMP;
      end
      CMP: begin
        if (bus.dut_s != bus.ref_s) begin
          err_d = err_q + 1'b1;
          if (!fval_q) begin
            fvec_d = stim_q;
            fval_d = 1'b1;
          end
        end
        // pass is derived from the post-compare count so the last vector is included
        if (&stim_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          stim_d  = stim_q + 1'b1;
          cnt_d   = SETTLE_C;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.stim            = stim_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_vec   = fvec_q;
  assign bus.first_err_valid = fval_q;
endmodule
